adc_cap_scheduler: RTL and testbench

- Round-robin scheduler that shares the single ADC capture datapath between NUM_REQ requesters (e.g. per-sensor capture engines, periodic capture timers).
- Grants one requester at a time and drives the ADC's active-low start strobe for a fixed hold time.
- Waits for the ADC completion pulse, with a timeout guard, then enforces a minimum inter-capture gap.
- Sits between the capture requesters and the ADC capture front end, in the same 40 MHz clock domain.

---
 rtl/adc_cap_scheduler_if.sv | 12 +
 rtl/adc_cap_scheduler.sv | 130 +++++++++++++
 tb/tb_adc_cap_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_cap_scheduler_if.sv
// adc_cap_scheduler_if: requester/ADC handshake bundle for the capture scheduler.
interface adc_cap_scheduler_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic               start_capture_n;
  logic               adc_done;
  logic               timeout_err;
  logic               busy;
  modport master (input req, adc_done, output grant, done, start_capture_n, timeout_err, busy);
  modport slave  (output req, adc_done, input grant, done, start_capture_n, timeout_err, busy);
endinterface

// File: rtl/adc_cap_scheduler.sv
// adc_cap_scheduler: round-robin owner of the ADC start strobe with hold, timeout and gap timing.
// Define ADC_CAP_SCHED_STATS_EN to add saturating capture/timeout counters with stats_clr.
module adc_cap_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int HOLD_TICKS    = 100,
  parameter int TIMEOUT_TICKS = 4096,
  parameter int MIN_GAP_TICKS = 16
) (
  input logic clk,
  input logic reset,
  adc_cap_scheduler_if.master bus
`ifdef ADC_CAP_SCHED_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] cap_count,
  output logic [7:0]  timeout_count
`endif
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int GW = MIN_GAP_TICKS > 0 ? $clog2(MIN_GAP_TICKS + 1) : 1;
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, HOLD, WAIT, GAP} state_t;
  state_t             state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [TW-1:0]      to_q, to_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [PW-1:0]      ptr_q, ptr_d, sel, idx;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic               start_n_q, start_n_d, tout_q, tout_d, busy_q, busy_d;
  // Scan downward so the last hit is the nearest set bit at or above the pointer.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.req[idx]) sel = idx;
    end
  end
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    to_d      = to_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    start_n_d = start_n_q;
    busy_d    = busy_q;
    done_d    = '0;
    tout_d    = 1'b0;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d   = HOLD;
        grant_d   = NUM_REQ'(1) << sel;
        start_n_d = 1'b0;
        busy_d    = 1'b1;
        hold_d    = HW'(HOLD_TICKS - 1);
        ptr_d     = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      end
      HOLD: if (hold_q == '0) begin
        state_d   = WAIT;
        start_n_d = 1'b1;
        to_d      = TW'(TIMEOUT_TICKS - 1);
      end else hold_d = hold_q - 1'b1;
      // adc_done wins over an expiry on the same edge.
      WAIT: if (bus.adc_done || to_q == '0) begin
        done_d  = bus.adc_done ? grant_q : '0;
        tout_d  = !bus.adc_done;
        grant_d = '0;
        state_d = MIN_GAP_TICKS == 0 ? IDLE : GAP;
        busy_d  = MIN_GAP_TICKS != 0;
        gap_d   = GW'(MIN_GAP_TICKS > 0 ? MIN_GAP_TICKS - 1 : 0);
      end else to_d = to_q - 1'b1;
      GAP: if (gap_q == '0) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else gap_d = gap_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      to_q      <= '0;
      gap_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      start_n_q <= 1'b1;
      tout_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      to_q      <= to_d;
      gap_q     <= gap_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      start_n_q <= start_n_d;
      tout_q    <= tout_d;
      busy_q    <= busy_d;
    end
  end
  assign bus.grant           = grant_q;
  assign bus.done            = done_q;
  assign bus.start_capture_n = start_n_q;
  assign bus.timeout_err     = tout_q;
  assign bus.busy            = busy_q;
`ifdef ADC_CAP_SCHED_STATS_EN
  logic [15:0] cap_q, cap_d;
  logic [7:0]  tcnt_q, tcnt_d;
  always_comb begin
    cap_d  = stats_clr ? '0 : (|done_d && !(&cap_q)) ? cap_q + 1'b1 : cap_q;
    tcnt_d = stats_clr ? '0 : (tout_d && !(&tcnt_q)) ? tcnt_q + 1'b1 : tcnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q  <= '0;
      tcnt_q <= '0;
    end else begin
      cap_q  <= cap_d;
      tcnt_q <= tcnt_d;
    end
  end
  assign cap_count     = cap_q;
  assign timeout_count = tcnt_q;
`endif
endmodule

// File: tb/tb_adc_cap_scheduler.sv
// tb_adc_cap_scheduler: directed checks of arbitration order, hold/timeout/gap timing and reset.
`timescale 1ns/1ps
module tb_adc_cap_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  adc_cap_scheduler_if #(.NUM_REQ(4)) bus();
`ifdef ADC_CAP_SCHED_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] cap_count;
  logic [7:0]  timeout_count;
`endif
  adc_cap_scheduler #(.NUM_REQ(4), .HOLD_TICKS(100), .TIMEOUT_TICKS(50), .MIN_GAP_TICKS(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef ADC_CAP_SCHED_STATS_EN
    , .stats_clr(stats_clr), .cap_count(cap_count), .timeout_count(timeout_count)
`endif
  );
  always #12.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic wait_grant(output int n);
    n = 0;
    while (bus.grant === 4'b0 && n < 400) begin @(negedge clk); n++; end
  endtask
  task automatic wait_hold(output int n);
    n = 0;
    while (bus.start_capture_n === 1'b0 && n < 400) begin @(negedge clk); n++; end
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
  endtask
  task automatic pulse_done_after(input int k);
    repeat (k - 1) @(negedge clk);
    bus.adc_done = 1'b1;
    @(negedge clk);
    bus.adc_done = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (bus.grant !== 4'b0) begin failures++; $display("FAIL rst_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.start_capture_n !== 1'b1) begin failures++; $display("FAIL rst_start_n got=%b exp=1", bus.start_capture_n); end
    checks++; if (bus.done !== 4'b0 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL rst_pulses done=%b tout=%b exp=0", bus.done, bus.timeout_err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
  endtask
  task automatic test_round_robin;
    int n, last;
    logic [3:0] exp;
    last = 0;
    bus.req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      exp = 4'(1 << (i % 4));
      wait_grant(n);
      checks++; if (bus.grant !== exp) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, bus.grant, exp); end
      if (i > 0) begin
        checks++; if (cyc - last != 122) begin failures++; $display("FAIL rr_spacing[%0d] got=%0d exp=122", i, cyc - last); end
      end
      last = cyc;
      wait_hold(n);
      pulse_done_after(5);
      checks++; if (bus.done !== exp) begin failures++; $display("FAIL rr_done[%0d] got=%b exp=%b", i, bus.done, exp); end
    end
    bus.req = 4'b0;
    wait_idle(n);
  endtask
  task automatic test_single;
    int n;
    repeat (10) @(negedge clk);
    bus.req = 4'b0100;
    @(negedge clk);
    checks++; if (bus.grant !== 4'b0100 || bus.start_capture_n !== 1'b0) begin failures++; $display("FAIL single_grant grant=%b start_n=%b exp=0100/0", bus.grant, bus.start_capture_n); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    bus.req = 4'b0;
    wait_hold(n);
    checks++; if (n != 100) begin failures++; $display("FAIL single_hold_len got=%0d exp=100", n); end
    checks++; if (bus.grant !== 4'b0100) begin failures++; $display("FAIL single_grant_held got=%b exp=0100", bus.grant); end
    pulse_done_after(20);
    checks++; if (bus.done !== 4'b0100 || bus.grant !== 4'b0) begin failures++; $display("FAIL single_done done=%b grant=%b exp=0100/0000", bus.done, bus.grant); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL single_no_tout got=%b exp=0", bus.timeout_err); end
    @(negedge clk);
    checks++; if (bus.done !== 4'b0) begin failures++; $display("FAIL single_done_width got=%b exp=0000", bus.done); end
    wait_idle(n);
    checks++; if (n != 15) begin failures++; $display("FAIL single_gap_len got=%0d exp=15", n); end
  endtask
  task automatic test_timeout;
    int n;
    logic seen_done;
    bus.req = 4'b0001;
    wait_grant(n);
    checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL to_grant got=%b exp=0001", bus.grant); end
    bus.req = 4'b0;
    wait_hold(n);
    n = 0;
    seen_done = 1'b0;
    while (bus.timeout_err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.done !== 4'b0) seen_done = 1'b1;
    end
    checks++; if (n != 50) begin failures++; $display("FAIL to_latency got=%0d exp=50", n); end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL to_no_done got=%b exp=0", seen_done); end
    checks++; if (bus.grant !== 4'b0) begin failures++; $display("FAIL to_grant_clr got=%b exp=0000", bus.grant); end
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", bus.timeout_err); end
    bus.req = 4'b0110;
    wait_grant(n);
    checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL to_next_grant got=%b exp=0010", bus.grant); end
    bus.req = 4'b0;
    wait_hold(n);
    pulse_done_after(3);
    checks++; if (bus.done !== 4'b0010) begin failures++; $display("FAIL to_next_done got=%b exp=0010", bus.done); end
    wait_idle(n);
  endtask
  task automatic test_spurious_boundary;
    int n;
    logic seen_done;
    bus.req = 4'b0100;
    wait_grant(n);
    checks++; if (bus.grant !== 4'b0100) begin failures++; $display("FAIL sp_grant got=%b exp=0100", bus.grant); end
    bus.req = 4'b0;
    n = 0;
    seen_done = 1'b0;
    while (bus.start_capture_n === 1'b0 && n < 400) begin
      bus.adc_done = (n == 30);
      @(negedge clk);
      n++;
      if (bus.done !== 4'b0) seen_done = 1'b1;
    end
    bus.adc_done = 1'b0;
    checks++; if (n != 100) begin failures++; $display("FAIL sp_hold_len got=%0d exp=100", n); end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL sp_hold_ignored got=%b exp=0", seen_done); end
    repeat (20) @(negedge clk);
    checks++; if (bus.done !== 4'b0 || bus.grant !== 4'b0100 || bus.busy !== 1'b1) begin failures++; $display("FAIL sp_waiting done=%b grant=%b busy=%b exp=0000/0100/1", bus.done, bus.grant, bus.busy); end
    repeat (29) @(negedge clk);
    bus.adc_done = 1'b1;
    @(negedge clk);
    bus.adc_done = 1'b0;
    checks++; if (bus.done !== 4'b0100 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL edge_done done=%b tout=%b exp=0100/0", bus.done, bus.timeout_err); end
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL edge_no_tout got=%b exp=0", bus.timeout_err); end
    wait_idle(n);
    bus.adc_done = 1'b1;
    @(negedge clk);
    bus.adc_done = 1'b0;
    checks++; if (bus.done !== 4'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL idle_done_ignored done=%b busy=%b exp=0000/0", bus.done, bus.busy); end
  endtask
  task automatic test_reset_mid_hold;
    int n;
    bus.req = 4'b0010;
    wait_grant(n);
    checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL mr_pre_grant got=%b exp=0010", bus.grant); end
    repeat (40) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.start_capture_n !== 1'b1 || bus.grant !== 4'b0) begin failures++; $display("FAIL mr_async start_n=%b grant=%b exp=1/0000", bus.start_capture_n, bus.grant); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", bus.busy); end
    bus.req = 4'b1010;
    @(negedge clk);
    checks++; if (bus.done !== 4'b0 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL mr_no_pulse done=%b tout=%b exp=0", bus.done, bus.timeout_err); end
    @(negedge clk);
    reset = 1'b1;
    wait_grant(n);
    checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL mr_ptr_reset got=%b exp=0010", bus.grant); end
    bus.req = 4'b0;
    wait_hold(n);
    pulse_done_after(2);
    checks++; if (bus.done !== 4'b0010) begin failures++; $display("FAIL mr_done got=%b exp=0010", bus.done); end
    wait_idle(n);
  endtask
`ifdef ADC_CAP_SCHED_STATS_EN
  task automatic test_stats;
    int n;
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checks++; if (cap_count !== 16'd0 || timeout_count !== 8'd0) begin failures++; $display("FAIL st_clr0 cap=%0d tout=%0d exp=0/0", cap_count, timeout_count); end
    for (int i = 0; i < 4; i++) begin
      bus.req = 4'b0001;
      wait_grant(n);
      bus.req = 4'b0;
      wait_hold(n);
      if (i < 3) pulse_done_after(4);
      else repeat (50) @(negedge clk);
      wait_idle(n);
    end
    checks++; if (cap_count !== 16'd3 || timeout_count !== 8'd1) begin failures++; $display("FAIL st_counts cap=%0d tout=%0d exp=3/1", cap_count, timeout_count); end
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checks++; if (cap_count !== 16'd0 || timeout_count !== 8'd0) begin failures++; $display("FAIL st_clr cap=%0d tout=%0d exp=0/0", cap_count, timeout_count); end
    bus.req = 4'b0001;
    wait_grant(n);
    bus.req = 4'b0;
    wait_hold(n);
    repeat (3) @(negedge clk);
    bus.adc_done = 1'b1;
    stats_clr = 1'b1;
    @(negedge clk);
    bus.adc_done = 1'b0;
    stats_clr = 1'b0;
    checks++; if (bus.done === 4'b0 || cap_count !== 16'd0) begin failures++; $display("FAIL st_clr_prio done=%b cap=%0d exp=nonzero/0", bus.done, cap_count); end
    wait_idle(n);
  endtask
`endif
  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req = 4'b0;
    bus.adc_done = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_spurious_boundary();
    test_reset_mid_hold();
`ifdef ADC_CAP_SCHED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
